cr_prefix_detach: RTL and testbench
===================================

Name: cr_prefix_detach

Overview:
- Inbound AXI4-S datapath TLV stripper. It is the receive-side counterpart of the prefix-attach stage.
- Parses the TLV stream, looks up a 2-bit per-type action, and drops or forwards each TLV whole.
- Checks TLV framing and length, and counts stripped TLVs.
- Sits after TLV-consuming engines, before the outbound packer; the TLV action table is selected by cceip_cfg.

Parameters:
- PREFIX_DETACH_STUB, 0, 1 = pure wire pass-through (ib->ob, no parsing, counters held 0).
- STRIP_CNT_W, 32, width of saturating stripped-TLV counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- prefix_detach_ib_in  in  axi4s_dp_bus_t  inbound beat (tvalid, tlast, tuser, tdata[63:0]). tuser[0] = start-of-TLV; tlast = end-of-TLV.
- prefix_detach_ib_out  out  axi4s_dp_rdy_t  inbound tready
- prefix_detach_ob_in  in  axi4s_dp_rdy_t  outbound tready
- prefix_detach_ob_out  out  axi4s_dp_bus_t  outbound beat
- tlv_parse_action_0  in  32  actions, types 0-15 (2 bits/type, type t at [2t+1:2t])
- tlv_parse_action_1  in  32  actions, types 16-31
- strip_cnt  out  STRIP_CNT_W  stripped TLVs, saturating
- tlvp_error  out  1  one-cycle error pulse
- prefix_detach_int  out  1  = tlvp_error

Behaviour:
- Clock and reset: single clock domain; all flops reset asynchronously on rst_n low.
- Reset values: ob_out.tvalid=0, ib_out.tready=0, strip_cnt=0, tlvp_error=0, FSM=HDR, beat_cnt=0, skid empty.
  - tready rises the first clk edge after rst_n deasserts.
- Header decode, on the first beat of each TLV:
  - type = tdata[7:0].
  - len = tdata[23:8], in 32-bit words including the header.
  - exp_beats = (len+1)>>1, computed 17 bits wide, no truncation.
  - Types 32-255 use action 00.
- Actions: 00 = pass, 01 = drop, 10 = pass, 11 = drop plus flag.
  - 11 pulses tlvp_error on the header beat; the TLV is still dropped.
- FSM states:
  - HDR: on accepted beat with tuser[0]=1, latch action and exp_beats, and set beat_cnt=1.
    - tlast=1 on the same beat means a single-beat TLV; stay in HDR.
    - Otherwise go to PASS or DROP.
  - PASS: forward each accepted beat unchanged; beat_cnt++. tlast -> HDR.
  - DROP: consume each beat, nothing emitted, beat_cnt++. tlast -> HDR.
  - Dropped beats still assert tready; backpressure applies only via the skid buffer.
- Framing error: beat in HDR with tuser[0]=0.
  - Pulse tlvp_error.
  - Forward beats until tlast (PASS semantics, no length check).
- Length error: at tlast, if beat_cnt != exp_beats, pulse tlvp_error one cycle after the tlast beat is accepted.
  - The TLV is still passed or dropped per its action; framing recovers at the next HDR.
- Simultaneous errors: framing and action-11 errors in the same cycle produce one pulse. The pulse is never stretched.
- strip_cnt increments by 1 on the header beat of each action-01/11 TLV and saturates at all-ones.
- Datapath: 2-entry skid buffer.
  - Latency is 1 cycle from ib accept to ob_out.tvalid when the buffer is empty.
  - ib_out.tready is registered: 1 when at most 1 entry is occupied.
  - Full throughput of 1 beat/cycle when ob tready=1.
  - ob_out.tvalid stays high and data stays stable while ob tready=0 (AXI rule).
  - Simultaneous push and pop keeps occupancy unchanged.
- Reset mid-TLV: outputs go to reset values immediately, the partial TLV is lost, and parsing restarts in HDR.
- Action registers are sampled only at header beats; changes mid-TLV take effect on the next TLV.

Decomposition:
- New cr_prefix_detachPKG, containing:
  - pd_state_e {HDR, PASS, DROP}
  - pd_action_e {PD_PASS=2'b00, PD_DROP=2'b01, PD_PASS2=2'b10, PD_DROP_FLAG=2'b11}
  - TLV field bit positions and the start-of-TLV tuser bit index.
- Sub-module cr_prefix_detach_skid: generic 2-entry AXI skid buffer on axi4s_dp_bus_t, reusable elsewhere.

Test Plan:
- Pass-through: actions all 00; TLVs type 1 len 5 (3 beats) then type 2 len 2 (1 beat), ob tready=1.
  - Expect 4 beats out, identical, 1-cycle latency, strip_cnt=0, no error.
- Drop: action type 9 = 01; sequence type1(3 beats), type9(4 beats, len 8), type1(2 beats).
  - Expect only 5 beats out, strip_cnt=1.
- Backpressure: ob tready toggling 1/0 every cycle during a 10-beat pass TLV.
  - Expect all 10 beats in order, none duplicated.
  - Expect ob data stable while stalled and ib tready to fall when 2 entries are held.
- Length error: header len 6 (exp 3 beats), tlast on beat 2.
  - Expect tlvp_error pulse exactly 1 cycle, prefix_detach_int equal to it.
  - Next TLV parsed normally.
- Framing error and flag action: first beat after reset with tuser[0]=0 -> error pulse, beats forwarded. Then type 31 with action 11 -> error pulse, TLV dropped, strip_cnt=1.
- Saturation and reset: with STRIP_CNT_W=4, strip 17 TLVs.
  - Expect strip_cnt=15.
  - Assert rst_n mid-TLV: outputs at reset values immediately; a fresh TLV after release passes.

Source files
------------

// File: rtl/cr_prefix_detach_pkg.sv
// Shared types for the inbound TLV prefix stripper: AXI4-S beat/ready structs, FSM and action encodings.
// TLV header layout: type in tdata[7:0], length (32-bit words incl. header) in tdata[23:8].
package cr_prefix_detach_pkg;

    localparam int TDATA_W       = 64;
    localparam int TUSER_W       = 8;
    localparam int TUSER_SOT_BIT = 0;
    localparam int TLV_TYPE_LSB  = 0;
    localparam int TLV_TYPE_MSB  = 7;
    localparam int TLV_LEN_LSB   = 8;
    localparam int TLV_LEN_MSB   = 23;
    localparam int EXP_BEATS_W   = 17;

    typedef struct packed {
        logic               tvalid;
        logic               tlast;
        logic [TUSER_W-1:0] tuser;
        logic [TDATA_W-1:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } pd_state_e;

    typedef enum logic [1:0] {
        PD_PASS      = 2'b00,
        PD_DROP      = 2'b01,
        PD_PASS2     = 2'b10,
        PD_DROP_FLAG = 2'b11
    } pd_action_e;

    // Two 32-bit words per 64-bit beat; widened first so len=16'hFFFF does not wrap.
    function automatic logic [EXP_BEATS_W-1:0] exp_beats(input logic [15:0] len);
        return ({1'b0, len} + 17'd1) >> 1;
    endfunction

endpackage

// File: rtl/cr_prefix_detach_if.sv
// Inbound/outbound AXI4-S beat and ready bundle of the prefix detach stage.
// slave = the stripper itself, master = the surrounding pipeline.
interface cr_prefix_detach_if;
    import cr_prefix_detach_pkg::*;

    axi4s_dp_bus_t prefix_detach_ib_in;
    axi4s_dp_rdy_t prefix_detach_ib_out;
    axi4s_dp_rdy_t prefix_detach_ob_in;
    axi4s_dp_bus_t prefix_detach_ob_out;

    modport slave (
        input  prefix_detach_ib_in,
        output prefix_detach_ib_out,
        input  prefix_detach_ob_in,
        output prefix_detach_ob_out
    );

    modport master (
        output prefix_detach_ib_in,
        input  prefix_detach_ib_out,
        output prefix_detach_ob_in,
        input  prefix_detach_ob_out
    );

endinterface

// File: rtl/cr_prefix_detach_skid.sv
// Generic 2-entry AXI4-S skid buffer; 1-cycle latency, 1 beat/cycle throughput.
// Registered o_in_rdy is high while at most one entry is held; output stays stable while stalled.
module cr_prefix_detach_skid
    import cr_prefix_detach_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  axi4s_dp_bus_t i_in_dat,
    output logic          o_in_rdy,
    output axi4s_dp_bus_t o_out_dat,
    input  logic          i_out_rdy
);

    axi4s_dp_bus_t r_mem [2];
    logic          r_head;
    logic [1:0]    r_cnt;
    logic          r_rdy;

    logic          w_push;
    logic          w_pop;
    logic          w_wr_idx;
    logic [1:0]    w_cnt_nxt;

    assign w_push    = i_in_dat.tvalid & r_rdy;
    assign w_pop     = (r_cnt != 2'd0) & i_out_rdy;
    assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    // A push only happens with 0 or 1 entries held, so the tail is head + cnt[0].
    assign w_wr_idx  = r_head ^ r_cnt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_cnt    <= 2'd0;
            r_rdy    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[w_wr_idx] <= i_in_dat;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_cnt <= w_cnt_nxt;
            r_rdy <= ~w_cnt_nxt[1];
        end
    end

    always_comb begin
        o_out_dat        = r_mem[r_head];
        o_out_dat.tvalid = (r_cnt != 2'd0);
    end

    assign o_in_rdy = r_rdy;

endmodule

// File: rtl/cr_prefix_detach.sv
// Inbound TLV stripper: forwards or drops whole TLVs per 2-bit type action, flags framing/length errors.
// 1-cycle ib->ob latency through a 2-entry skid; dropped beats are still accepted, stalls come only from the skid.
module cr_prefix_detach
    import cr_prefix_detach_pkg::*;
#(
    parameter int PREFIX_DETACH_STUB = 0,
    parameter int STRIP_CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cr_prefix_detach_if.slave      dp,
    input  logic [31:0]            tlv_parse_action_0,
    input  logic [31:0]            tlv_parse_action_1,
    output logic [STRIP_CNT_W-1:0] strip_cnt,
    output logic                   tlvp_error,
    output logic                   prefix_detach_int
);

    assign prefix_detach_int = tlvp_error;

    generate
        if (PREFIX_DETACH_STUB != 0) begin : g_stub
            assign dp.prefix_detach_ob_out = dp.prefix_detach_ib_in;
            assign dp.prefix_detach_ib_out = dp.prefix_detach_ob_in;
            assign strip_cnt               = '0;
            assign tlvp_error              = 1'b0;
        end else begin : g_parse
            axi4s_dp_bus_t          w_ib_dat;
            axi4s_dp_bus_t          w_skid_in_dat;
            axi4s_dp_bus_t          w_skid_out_dat;
            logic                   w_ib_rdy;
            logic                   w_ob_rdy;
            logic                   w_accept;
            logic                   w_sot;
            logic [7:0]             w_type;
            logic [15:0]            w_len;
            logic [63:0]            w_act_tbl;
            pd_action_e             w_act;
            logic [EXP_BEATS_W-1:0] w_hdr_exp;
            logic [EXP_BEATS_W-1:0] w_cnt_inc;

            pd_state_e              r_state;
            pd_state_e              w_state_nxt;
            logic [EXP_BEATS_W-1:0] r_beat_cnt;
            logic [EXP_BEATS_W-1:0] w_beat_cnt_nxt;
            logic [EXP_BEATS_W-1:0] r_exp_beats;
            logic [EXP_BEATS_W-1:0] w_exp_beats_nxt;
            logic                   r_no_len_chk;
            logic                   w_no_len_chk_nxt;
            logic                   w_fwd;
            logic                   w_err;
            logic                   w_strip_inc;
            logic                   r_err;
            logic [STRIP_CNT_W-1:0] r_strip_cnt;

            assign w_ib_dat  = dp.prefix_detach_ib_in;
            assign w_ob_rdy  = dp.prefix_detach_ob_in.tready;
            assign w_accept  = w_ib_dat.tvalid & w_ib_rdy;
            assign w_sot     = w_ib_dat.tuser[TUSER_SOT_BIT];
            assign w_type    = w_ib_dat.tdata[TLV_TYPE_MSB:TLV_TYPE_LSB];
            assign w_len     = w_ib_dat.tdata[TLV_LEN_MSB:TLV_LEN_LSB];
            assign w_hdr_exp = exp_beats(w_len);
            assign w_cnt_inc = r_beat_cnt + 17'd1;
            assign w_act_tbl = {tlv_parse_action_1, tlv_parse_action_0};
            // Types 32..255 have no table entry and always pass.
            assign w_act     = (w_type[7:5] == 3'd0) ?
                               pd_action_e'(w_act_tbl[{w_type[4:0], 1'b0} +: 2]) : PD_PASS;

            always_comb begin
                w_state_nxt      = r_state;
                w_beat_cnt_nxt   = r_beat_cnt;
                w_exp_beats_nxt  = r_exp_beats;
                w_no_len_chk_nxt = r_no_len_chk;
                w_fwd            = 1'b0;
                w_err            = 1'b0;
                w_strip_inc      = 1'b0;
                if (w_accept) begin
                    unique case (r_state)
                        HDR: begin
                            w_beat_cnt_nxt = 17'd1;
                            if (w_sot) begin
                                w_exp_beats_nxt  = w_hdr_exp;
                                w_no_len_chk_nxt = 1'b0;
                                w_fwd            = ~w_act[0];
                                w_strip_inc      = w_act[0];
                                w_err            = (w_act == PD_DROP_FLAG) |
                                                   (w_ib_dat.tlast & (w_hdr_exp != 17'd1));
                                if (!w_ib_dat.tlast) begin
                                    w_state_nxt = w_act[0] ? DROP : PASS;
                                end
                            end else begin
                                // Lost framing: forward to tlast blindly, length unknown.
                                w_no_len_chk_nxt = 1'b1;
                                w_fwd            = 1'b1;
                                w_err            = 1'b1;
                                if (!w_ib_dat.tlast) begin
                                    w_state_nxt = PASS;
                                end
                            end
                        end
                        PASS, DROP: begin
                            w_fwd          = (r_state == PASS);
                            w_beat_cnt_nxt = w_cnt_inc;
                            if (w_ib_dat.tlast) begin
                                w_err       = ~r_no_len_chk & (w_cnt_inc != r_exp_beats);
                                w_state_nxt = HDR;
                            end
                        end
                        default: begin
                            w_state_nxt = HDR;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state      <= HDR;
                    r_beat_cnt   <= '0;
                    r_exp_beats  <= '0;
                    r_no_len_chk <= 1'b0;
                    r_err        <= 1'b0;
                    r_strip_cnt  <= '0;
                end else begin
                    r_state      <= w_state_nxt;
                    r_beat_cnt   <= w_beat_cnt_nxt;
                    r_exp_beats  <= w_exp_beats_nxt;
                    r_no_len_chk <= w_no_len_chk_nxt;
                    r_err        <= w_err;
                    if (w_strip_inc && (r_strip_cnt != {STRIP_CNT_W{1'b1}})) begin
                        r_strip_cnt <= r_strip_cnt + {{(STRIP_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end

            always_comb begin
                w_skid_in_dat        = w_ib_dat;
                w_skid_in_dat.tvalid = w_fwd;
            end

            cr_prefix_detach_skid u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_in_dat  (w_skid_in_dat),
                .o_in_rdy  (w_ib_rdy),
                .o_out_dat (w_skid_out_dat),
                .i_out_rdy (w_ob_rdy)
            );

            assign dp.prefix_detach_ib_out  = '{tready: w_ib_rdy};
            assign dp.prefix_detach_ob_out  = w_skid_out_dat;
            assign strip_cnt                = r_strip_cnt;
            assign tlvp_error               = r_err;
        end
    endgenerate

endmodule

// File: tb/tb_cr_prefix_detach.sv
// Directed bench for cr_prefix_detach: TLV-level expectation model plus a per-cycle output checker.
module tb_cr_prefix_detach;

    localparam int CW  = 4;
    localparam int SAT = 15;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  u;
        logic        l;
    } exp_t;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [31:0]   act0   = '0;
    logic [31:0]   act1   = '0;
    logic          ob_rdy = 1'b1;
    logic [CW-1:0] strip_cnt;
    logic          tlvp_error;
    logic          prefix_detach_int;

    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   err_seen  = 0;
    int   err_exp   = 0;
    int   strip_exp = 0;
    int   out_cnt   = 0;
    int   serial    = 0;
    int   base;
    bit   bp_on      = 1'b0;
    bit   g_fwd      = 1'b0;
    bit   lat_chk    = 1'b0;
    bit   saw_ib_low = 1'b0;
    bit   prev_stall = 1'b0;
    logic [63:0] prev_dat;
    exp_t q[$];
    exp_t e_cur;

    cr_prefix_detach_if ifc ();

    cr_prefix_detach #(
        .PREFIX_DETACH_STUB (0),
        .STRIP_CNT_W        (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dp                 (ifc),
        .tlv_parse_action_0 (act0),
        .tlv_parse_action_1 (act1),
        .strip_cnt          (strip_cnt),
        .tlvp_error         (tlvp_error),
        .prefix_detach_int  (prefix_detach_int)
    );

    assign ifc.prefix_detach_ob_in = '{tready: ob_rdy};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ob_rdy = bp_on ? ~ob_rdy : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_action(input int t);
        logic [31:0] v;
        if (t >= 32) return 0;
        v = (t < 16) ? (act0 >> (2 * t)) : (act1 >> (2 * (t - 16)));
        return int'(v & 32'd3);
    endfunction

    function automatic logic [63:0] hdr_word(input int t, input int len);
        return {32'(serial), 8'h00, 16'(len), 8'(t)};
    endfunction

    function automatic logic [63:0] body_word(input int i);
        return {32'(serial), 16'hBEEF, 16'(i)};
    endfunction

    // Present one beat and hold it until it is accepted; forwarded beats join the expected stream.
    task automatic drive(input logic [63:0] d, input logic sot, input logic last);
        int   guard;
        exp_t e;
        ifc.prefix_detach_ib_in.tvalid = 1'b1;
        ifc.prefix_detach_ib_in.tdata  = d;
        ifc.prefix_detach_ib_in.tuser  = {7'd0, sot};
        ifc.prefix_detach_ib_in.tlast  = last;
        guard = 0;
        while (ifc.prefix_detach_ib_out.tready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ib_accept_timeout: tready stuck at %b, expected 1", ifc.prefix_detach_ib_out.tready);
        end
        @(posedge clk); #1;
        if (g_fwd) begin
            e.d = d;
            e.u = {7'd0, sot};
            e.l = last;
            q.push_back(e);
        end
        if (lat_chk) begin
            chk("latency_tvalid", ifc.prefix_detach_ob_out.tvalid, 1);
            chk("latency_tdata", ifc.prefix_detach_ob_out.tdata, d);
            lat_chk = 1'b0;
        end
    endtask

    // TLV-level model: decide fate, strip count and error pulses from the action table and length rule.
    task automatic send_tlv(input int t, input int len, input int nb, input bit sot);
        int a;
        int expb;
        bit hdr_err;
        bit len_err;
        serial++;
        a = model_action(t);
        if (!sot) begin
            g_fwd = 1'b1;
            err_exp++;
        end else begin
            g_fwd   = (a == 0) || (a == 2);
            if (!g_fwd && strip_exp < SAT) strip_exp++;
            expb    = (len + 1) / 2;
            hdr_err = (a == 3);
            len_err = (nb != expb);
            if (nb == 1) err_exp += int'(hdr_err || len_err);
            else         err_exp += int'(hdr_err) + int'(len_err);
        end
        for (int i = 0; i < nb; i++) begin
            drive((i == 0) ? hdr_word(t, len) : body_word(i), sot && (i == 0), i == nb - 1);
        end
    endtask

    task automatic drain();
        int g;
        ifc.prefix_detach_ib_in.tvalid = 1'b0;
        g = 0;
        while ((q.size() != 0 || ifc.prefix_detach_ob_out.tvalid) && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still expected, expected 0", q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("int_equals_error", prefix_detach_int, tlvp_error);
            if (tlvp_error) err_seen++;
            if (!ifc.prefix_detach_ib_out.tready) saw_ib_low = 1'b1;
            if (prev_stall) begin
                chk("stall_tvalid_held", ifc.prefix_detach_ob_out.tvalid, 1);
                chk("stall_tdata_stable", ifc.prefix_detach_ob_out.tdata, prev_dat);
            end
            if (ifc.prefix_detach_ob_out.tvalid && ob_rdy) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ob_beat: got tdata %0h, expected no beat", ifc.prefix_detach_ob_out.tdata);
                end else begin
                    e_cur = q.pop_front();
                    chk("ob_tdata", ifc.prefix_detach_ob_out.tdata, e_cur.d);
                    chk("ob_tuser", ifc.prefix_detach_ob_out.tuser, e_cur.u);
                    chk("ob_tlast", ifc.prefix_detach_ob_out.tlast, e_cur.l);
                    out_cnt++;
                end
            end
            prev_stall = ifc.prefix_detach_ob_out.tvalid && !ob_rdy;
            prev_dat   = ifc.prefix_detach_ob_out.tdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        ifc.prefix_detach_ib_in = '0;
        #3;
        chk("rst_ob_tvalid", ifc.prefix_detach_ob_out.tvalid, 0);
        chk("rst_ib_tready", ifc.prefix_detach_ib_out.tready, 0);
        chk("rst_strip_cnt", strip_cnt, 0);
        chk("rst_tlvp_error", tlvp_error, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("tready_low_at_release", ifc.prefix_detach_ib_out.tready, 0);
        @(posedge clk); #1;
        chk("tready_first_edge", ifc.prefix_detach_ib_out.tready, 1);

        // Pass-through of a 3-beat and a 1-beat TLV.
        base    = out_cnt;
        lat_chk = 1'b1;
        send_tlv(1, 5, 3, 1);
        send_tlv(2, 2, 1, 1);
        drain();
        chk("pass_beats_out", out_cnt - base, 4);
        chk("pass_strip_cnt", strip_cnt, 0);
        chk("pass_no_error", err_seen, 0);

        // Type 9 dropped.
        act0 = 32'h0004_0000;
        base = out_cnt;
        send_tlv(1, 5, 3, 1);
        send_tlv(9, 8, 4, 1);
        send_tlv(1, 4, 2, 1);
        drain();
        chk("drop_beats_out", out_cnt - base, 5);
        chk("drop_strip_cnt", strip_cnt, 1);
        chk("drop_strip_model", strip_cnt, strip_exp);

        // Outbound tready toggling during a 10-beat TLV.
        base       = out_cnt;
        saw_ib_low = 1'b0;
        bp_on      = 1'b1;
        send_tlv(2, 20, 10, 1);
        drain();
        bp_on = 1'b0;
        chk("bp_beats_out", out_cnt - base, 10);
        chk("bp_ib_tready_fell", saw_ib_low, 1);

        // Length error: len 6 wants 3 beats, tlast on beat 2.
        serial++;
        g_fwd = 1'b1;
        err_exp++;
        drive(hdr_word(3, 6), 1'b1, 1'b0);
        drive(body_word(1), 1'b0, 1'b1);
        ifc.prefix_detach_ib_in.tvalid = 1'b0;
        chk("lenerr_pulse", tlvp_error, 1);
        chk("lenerr_int", prefix_detach_int, 1);
        @(posedge clk); #1;
        chk("lenerr_one_cycle", tlvp_error, 0);
        base = out_cnt;
        send_tlv(1, 2, 1, 1);
        drain();
        chk("lenerr_next_tlv_out", out_cnt - base, 1);
        chk("lenerr_total", err_seen, 1);
        chk("lenerr_model", err_seen, err_exp);

        // Framing error right after reset, then a flagged drop of type 31.
        ifc.prefix_detach_ib_in.tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        strip_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_clears_strip", strip_cnt, 0);
        act1 = 32'hC000_0000;
        base = out_cnt;
        send_tlv(5, 4, 2, 0);
        send_tlv(31, 4, 2, 1);
        drain();
        chk("frm_beats_out", out_cnt - base, 2);
        chk("flag_strip_cnt", strip_cnt, 1);
        chk("frm_flag_errors", err_seen, 3);
        chk("frm_flag_model", err_seen, err_exp);

        // Saturating strip counter.
        for (int i = 0; i < 17; i++) send_tlv(9, 2, 1, 1);
        drain();
        chk("sat_strip_cnt", strip_cnt, 15);
        chk("sat_strip_model", strip_cnt, strip_exp);
        chk("sat_no_new_error", err_seen, err_exp);

        // Reset in the middle of a TLV.
        serial++;
        g_fwd = 1'b1;
        drive(hdr_word(1, 6), 1'b1, 1'b0);
        drive(body_word(1), 1'b0, 1'b0);
        ifc.prefix_detach_ib_in.tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ob_tvalid", ifc.prefix_detach_ob_out.tvalid, 0);
        chk("midrst_ib_tready", ifc.prefix_detach_ib_out.tready, 0);
        chk("midrst_strip_cnt", strip_cnt, 0);
        chk("midrst_tlvp_error", tlvp_error, 0);
        q.delete();
        strip_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = out_cnt;
        send_tlv(1, 2, 1, 1);
        drain();
        chk("midrst_fresh_tlv_out", out_cnt - base, 1);
        chk("midrst_final_errors", err_seen, err_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
